// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam int DIV_WIDTH = 8;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] trial;

    // The 9-bit trial value carries the remainder's extra bit; the restored result always fits WIDTH bits.
    always_comb begin
        trial = {rem_i, bit_i};
        q_o   = (trial >= {1'b0, divisor_i});
        rem_o = q_o ? (trial[WIDTH-1:0] - divisor_i) : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/day6_8bit_div.sv
// Sequential unsigned divider, one quotient bit per clock behind a start/done handshake.
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one restoring iteration per cycle, counter counts down to 0
// DONE  | done pulse cycle, then back to IDLE
module day6_8bit_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quot_d;
    logic             q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dividend_q[WIDTH-1]),
        .divisor_i (divisor_q),
        .rem_o     (rem_d),
        .q_o       (q_bit)
    );

    assign quot_d = {quot_q[WIDTH-2:0], q_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dividend_q <= A;
                        divisor_q  <= B;
                        rem_q      <= '0;
                        quot_q     <= '0;
                        cnt_q      <= CW'(WIDTH - 1);
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    dividend_q <= {dividend_q[WIDTH-2:0], 1'b0};
                    rem_q      <= rem_d;
                    quot_q     <= quot_d;
                    cnt_q      <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quotient_q  <= quot_d;
                        remainder_q <= rem_d;
                        dbz_q       <= (divisor_q == '0);
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Quotient    = quotient_q;
    assign Remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_day6_8bit_div.sv
// Directed scoreboard bench for day6_8bit_div: launch, wait for done, compare against queued expectations.
module tb_day6_8bit_div;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    day6_8bit_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t expect_div(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q  = 8'hFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Launch a/b, check latency and results; with hold_start, start stays high (new operands) through RUN and DONE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold_start);
        int   cyc;
        exp_t e;
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        sb.push_back(expect_div(a, b));
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        A = 8'($urandom_range(0, 255));
        B = 8'($urandom_range(0, 255));
        check("busy_after_start", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (hold_start) begin
                A = 8'($urandom_range(0, 255));
                B = 8'($urandom_range(0, 255));
            end
        end
        check("latency", cyc, 32'd8);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("quotient", {24'd0, Quotient}, {24'd0, e.q});
            check("remainder", {24'd0, Remainder}, {24'd0, e.r});
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
            check("busy_in_done", {31'd0, busy}, 32'd1);
            @(negedge clk);
            start = 1'b0;
            check("done_drops", {31'd0, done}, 32'd0);
            check("busy_drops", {31'd0, busy}, 32'd0);
            check("quotient_held", {24'd0, Quotient}, {24'd0, e.q});
            check("remainder_held", {24'd0, Remainder}, {24'd0, e.r});
            if (hold_start) begin
                @(negedge clk);
                check("no_relaunch_from_done", {31'd0, busy}, 32'd0);
            end
        end
    endtask

    initial begin
        int guard;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        A     = 8'd0;
        B     = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_quotient", {24'd0, Quotient}, 32'd0);
        check("rst_remainder", {24'd0, Remainder}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'd5, 8'd25, 1'b0);
        run_op(8'd13, 8'd28, 1'b0);
        run_op(8'd6, 8'd37, 1'b0);
        run_op(8'd200, 8'd7, 1'b0);
        run_op(8'd255, 8'd1, 1'b0);
        run_op(8'd255, 8'd255, 1'b0);
        run_op(8'd77, 8'd0, 1'b0);
        run_op(8'd0, 8'd9, 1'b0);
        run_op(8'd0, 8'd0, 1'b0);
        run_op(8'd200, 8'd7, 1'b1);
        run_op(8'd99, 8'd10, 1'b0);

        // Launch, then reset asynchronously in the middle of iteration 4.
        @(negedge clk);
        A     = 8'd50;
        B     = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_quotient", {24'd0, Quotient}, 32'd0);
        check("midrst_remainder", {24'd0, Remainder}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        guard = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) guard++;
        end
        check("no_done_after_rst", guard, 32'd0);

        run_op(8'd100, 8'd9, 1'b0);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
